tick_scheduler: RTL and testbench
=================================

// Module: tick_scheduler
// PURPOSE
//  Synthesizable run/stop controller producing a programmable periodic tick and a derived
//  divided clock-enable waveform for datapaths. Counterpart of the behavioural clock
//  generator: same period/stop semantics, but cycle-accurate on one system clock.
//  Sits between control logic (start/stop) and any block needing paced enables.
// PARAMETERS
//  DIV_W   16  width of period config; period in clk cycles, 1..2**DIV_W-1
//  CNT_W   16  width of tick-count config and tick counter
// PORTS
//  clk        in   1      system clock, all logic on rising edge
//  rst_n      in   1      synchronous reset, active-low
//  start      in   1      run request; accepted only in IDLE
//  stop       in   1      stop request; sampled only in RUN
//  cfg_div    in   DIV_W  period in cycles; sampled on accepted start
//  cfg_count  in   CNT_W  ticks to emit; 0 = free-run until stop; sampled on accepted start
//  tick       out  1      1-cycle pulse on last cycle of each period
//  div_clk    out  1      divided waveform: 0 first floor(div/2) cycles of period, 1 rest
//  clk_en     out  1      high in RUN and STOPPING
//  busy       out  1      high in any state except IDLE
//  done       out  1      1-cycle pulse in DONE
//  tick_cnt   out  CNT_W  ticks emitted since accepted start (wraps in free-run)
// BEHAVIOUR
//  - Clock/reset: one clock; reset is synchronous and active-low (rst_n sampled on clk).
//  - Reset: state IDLE; tick, div_clk, clk_en, busy, done = 0; tick_cnt = 0; regs cleared.
//    rst_n low mid-operation aborts immediately to IDLE, no done pulse.
//  - States: IDLE, RUN, STOPPING, DONE.
//    IDLE -start-> RUN (latch div_q = max(cfg_div,1), count_q = cfg_count, cyc=0, tick_cnt=0)
//    RUN  -stop, no tick this cycle-> STOPPING
//    RUN  -tick and (stop or tick_cnt+1==count_q, count_q!=0)-> DONE
//    STOPPING -tick-> DONE (current period always completed, never truncated)
//    DONE -> IDLE unconditionally after one cycle
//  - Period counter cyc: 0..div_q-1 in RUN/STOPPING, wraps to 0 after div_q-1.
//    tick = (cyc == div_q-1) in RUN/STOPPING. First tick div_q cycles after start edge:
//    start high at edge N -> RUN from N+1 -> tick in cycle N+div_q.
//  - div_clk = (cyc >= div_q>>1) in RUN/STOPPING, else 0. div_q=1: div_clk const 1, tick
//    every cycle.
//  - tick_cnt increments in the tick cycle (registered, visible next cycle); held in DONE/IDLE
//    until next accepted start; wraps mod 2**CNT_W.
//  - start outside IDLE ignored; cfg_* changes after acceptance ignored.
//  - start and stop together in IDLE: start accepted, stop ignored.
//  - stop in STOPPING/DONE/IDLE ignored (no effect, no extra done).
//  - Stop coinciding with count-terminal tick: single DONE, single done pulse.
//  - All outputs registered-state-derived; no combinational path from start/stop to outputs.
// STRUCTURE
//  - tick_sched_pkg: state enum (IDLE,RUN,STOPPING,DONE), DIV_W/CNT_W defaults,
//    helper function terminal(cyc,div) returning cyc==div-1.
//  - Sub-module tick_period_cnt: cyc counter + tick/div_clk decode, enable and clear inputs.
//  - Top: FSM, config latches, tick_cnt, done/busy/clk_en decode.
// TESTING
//  1 Reset: hold rst_n=0 3 cycles with start=1 -> all outputs 0, state IDLE, no done.
//  2 cfg_div=4,cfg_count=3,start pulse at cycle 0 -> tick at cycles 4,8,12; div_clk 0011
//    per period; done at cycle 13; busy low from 14; tick_cnt=3.
//  3 cfg_div=5,count=0,start; stop at cycle 7 -> STOPPING, final tick cycle 10, done 11,
//    tick_cnt=2.
//  4 cfg_div=1,count=4 -> tick cycles 1..4 back-to-back, div_clk=1, done cycle 5.
//  5 count=2,div=3: stop asserted on 2nd tick cycle (6) -> exactly one done (7); start during
//    RUN with cfg_div=9 ignored, period stays 3.
//  6 Reset mid-run: rst_n=0 at cycle 5 of div=4 run -> IDLE next edge, no done, tick_cnt=0.

Source files
------------

// File: rtl/tick_sched_pkg.sv
// Shared types and helpers for the tick scheduler: FSM state encoding,
// default widths and the period-terminal test.
package tick_sched_pkg;
  localparam int DIV_W_DEF = 16;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2,
    DONE     = 2'd3
  } state_t;

  // Widths up to 32 bits; a zero divisor never matches, so an unloaded counter stays quiet.
  function automatic logic terminal(input logic [31:0] cyc, input logic [31:0] div);
    return cyc == (div - 32'd1);
  endfunction
endpackage

// File: rtl/tick_scheduler_if.sv
// Control/status bundle between a run/stop controller and the tick scheduler.
interface tick_scheduler_if #(
  parameter int DIV_W = 16,
  parameter int CNT_W = 16
);
  logic             start;
  logic             stop;
  logic [DIV_W-1:0] cfg_div;
  logic [CNT_W-1:0] cfg_count;
  logic             tick;
  logic             div_clk;
  logic             clk_en;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] tick_cnt;

  modport master (
    output start, stop, cfg_div, cfg_count,
    input  tick, div_clk, clk_en, busy, done, tick_cnt
  );

  modport slave (
    input  start, stop, cfg_div, cfg_count,
    output tick, div_clk, clk_en, busy, done, tick_cnt
  );
endinterface

// File: rtl/tick_period_cnt.sv
// Period counter: walks cyc through 0..div-1 while enabled and decodes the
// end-of-period tick and the low-then-high divided waveform.
module tick_period_cnt
  import tick_sched_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick,
  output logic             div_clk
);
  logic [DIV_W-1:0] cyc;
  logic             term;

  assign term = terminal(32'(cyc), 32'(div));

  always_ff @(posedge clk) begin
    if (!rst_n)   cyc <= '0;
    else if (clr) cyc <= '0;
    else if (en)  cyc <= term ? '0 : cyc + DIV_W'(1);
  end

  // With div==1 the threshold is 0, so the waveform sits high and every cycle ticks.
  assign tick    = en & term;
  assign div_clk = en & (cyc >= (div >> 1));
endmodule

// File: rtl/tick_scheduler.sv
// Run/stop controller emitting a programmable periodic tick, a divided
// enable waveform and a tick count, all decoded from registered state.
module tick_scheduler
  import tick_sched_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  tick_scheduler_if.slave  bus
);
  state_t           state;
  logic [DIV_W-1:0] div_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] tick_cnt;
  logic [CNT_W-1:0] tick_cnt_nx;
  logic             run;
  logic             busy;
  logic             done;
  logic             idle;
  logic             tick;
  logic             div_clk;
  logic             last;

  assign idle        = (state == IDLE);
  assign tick_cnt_nx = tick_cnt + CNT_W'(1);
  // Stop on a tick cycle and count exhaustion both land in the same single DONE.
  assign last        = bus.stop || ((count_q != '0) && (tick_cnt_nx == count_q));

  tick_period_cnt #(.DIV_W(DIV_W)) u_period (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (run),
    .clr     (idle),
    .div     (div_q),
    .tick    (tick),
    .div_clk (div_clk)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      div_q    <= '0;
      count_q  <= '0;
      tick_cnt <= '0;
      run      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= RUN;
            div_q    <= (bus.cfg_div == '0) ? DIV_W'(1) : bus.cfg_div;
            count_q  <= bus.cfg_count;
            tick_cnt <= '0;
            run      <= 1'b1;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          if (tick) begin
            tick_cnt <= tick_cnt_nx;
            if (last) begin
              state <= DONE;
              run   <= 1'b0;
              done  <= 1'b1;
            end
          end else if (bus.stop) begin
            state <= STOPPING;
          end
        end
        STOPPING: begin
          // The running period always completes before DONE.
          if (tick) begin
            tick_cnt <= tick_cnt_nx;
            state    <= DONE;
            run      <= 1'b0;
            done     <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          run   <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tick     = tick;
  assign bus.div_clk  = div_clk;
  assign bus.clk_en   = run;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.tick_cnt = tick_cnt;
endmodule

// File: tb/tb_tick_scheduler.sv
// Scoreboard bench: each driven cycle pushes the expected output flags and
// tick count; a negedge monitor pops and compares one entry per cycle.
module tb_tick_scheduler;
  import tick_sched_pkg::*;

  localparam int DIV_W = 16;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tick_scheduler_if #(.DIV_W(DIV_W), .CNT_W(CNT_W)) bus ();

  tick_scheduler #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string      tag;
    logic [4:0] flags;   // {tick, div_clk, clk_en, busy, done}
    int         tcnt;    // -1 = tick_cnt not checked this cycle
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic push(input string tag, input logic [4:0] flags, input int tcnt);
    exp_t e;
    e.tag   = tag;
    e.flags = flags;
    e.tcnt  = tcnt;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check({mon_e.tag, " flags"},
            32'({bus.tick, bus.div_clk, bus.clk_en, bus.busy, bus.done}), 32'(mon_e.flags));
      if (mon_e.tcnt >= 0)
        check({mon_e.tag, " tick_cnt"}, 32'(bus.tick_cnt), 32'(mon_e.tcnt));
    end
  end

  // Cycle c=0 is the cycle start is held high; expectations come from the
  // closed-form timing: ticks at k*div, done one cycle after the final tick.
  task automatic run_case(input int id, input int div, input int count, input int stop_c,
                          input int start_c, input int start_div, input int rst_c);
    int    d;
    int    last_t;
    int    ncyc;
    string tag;
    d      = (div == 0) ? 1 : div;
    last_t = (count != 0) ? count * d : 32'h7fff_ffff;
    if (stop_c >= 1 && stop_c <= last_t) last_t = ((stop_c + d - 1) / d) * d;
    ncyc   = (rst_c >= 0) ? rst_c + 2 : last_t + 2;
    for (int c = 0; c <= ncyc; c++) begin
      @(posedge clk); #1;
      bus.start     = (c == 0) || (c == start_c);
      bus.cfg_div   = (c == start_c) ? DIV_W'(start_div) : DIV_W'(div);
      bus.cfg_count = CNT_W'(count);
      bus.stop      = (c == stop_c);
      rst_n         = (c != rst_c);
      tag = $sformatf("case%0d cyc%0d", id, c);
      if (rst_c >= 0 && c > rst_c)
        push(tag, 5'b00000, 0);
      else if (c == 0)
        push(tag, 5'b00000, -1);
      else if (c <= last_t)
        push(tag, {(c % d) == 0, ((c - 1) % d) >= (d / 2), 1'b1, 1'b1, 1'b0}, (c - 1) / d);
      else if (c == last_t + 1)
        push(tag, 5'b00011, last_t / d);
      else
        push(tag, 5'b00000, last_t / d);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.start     = 1'b1;
    bus.stop      = 1'b0;
    bus.cfg_div   = DIV_W'(4);
    bus.cfg_count = CNT_W'(1);
    // Reset held with start asserted: everything must stay at zero.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      push($sformatf("reset cyc%0d", i), 5'b00000, 0);
    end
    @(posedge clk); #1;
    rst_n     = 1'b1;
    bus.start = 1'b0;
    push("reset release", 5'b00000, 0);

    //       id div cnt stop st_c st_div rst
    run_case(2, 4,  3,  -1,  -1,  0,    -1);
    run_case(3, 5,  0,   7,  -1,  0,    -1);
    run_case(4, 1,  4,  -1,  -1,  0,    -1);
    run_case(5, 3,  2,   6,   2,  9,    -1);
    run_case(6, 4,  0,  -1,  -1,  0,     5);
    run_case(7, 2,  2,   0,  -1,  0,    -1);
    run_case(8, 3,  1,   4,  -1,  0,    -1);
    run_case(9, 0,  2,  -1,  -1,  0,    -1);

    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
